// File: rtl/usb_rx_deserializer_if.sv
// USB RX deserializer bus: serial bit input side and word/status output side.
// master drives the serial stream, slave is the deserializer.
interface usb_rx_deserializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int HIST_DEPTH = 3
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic                           clear;
  logic                           shift_enable;
  logic                           d_in;
  logic [DATA_WIDTH-1:0]          rx_data;
  logic                           rx_data_valid;
  logic [DATA_WIDTH*HIST_DEPTH-1:0] rx_history;
  logic                           stuff_skip;
  logic                           stuff_error;
  logic [CW-1:0]                  bit_count;

  modport master (
    output clear, shift_enable, d_in,
    input  rx_data, rx_data_valid, rx_history,
    input  stuff_skip, stuff_error, bit_count
  );

  modport slave (
    input  clear, shift_enable, d_in,
    output rx_data, rx_data_valid, rx_history,
    output stuff_skip, stuff_error, bit_count
  );
endinterface

// File: rtl/usb_rx_deserializer.sv
// USB RX deserializer: bit destuffing, word assembly, history window.
// Stuff bits are removed before the word shifter; ones run spans words.
module usb_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int HIST_DEPTH = 3,
  parameter int MAX_ONES   = 6,
  parameter bit LSB_FIRST  = 1'b1
) (
  input logic clk,
  input logic rst,
  usb_rx_deserializer_if.slave rx
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int OW = $clog2(MAX_ONES + 1);
  localparam int HW = DATA_WIDTH * HIST_DEPTH;

  logic [DATA_WIDTH-1:0] sreg;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [HW-1:0]         hist;
  logic [HW-1:0]         hist_nxt;
  logic [CW-1:0]         bcnt;
  logic [OW-1:0]         ones;
  logic                  valid_q;
  logic                  skip_q;
  logic                  err_q;
  logic                  stuff_pos;
  logic                  word_done;

  // next word image, shifted history and bit classification
  always_comb begin
    word_nxt = '0;
    if (LSB_FIRST)
      word_nxt = {rx.d_in, sreg[DATA_WIDTH-1:1]};
    else
      word_nxt = {sreg[DATA_WIDTH-2:0], rx.d_in};
    hist_nxt = hist << DATA_WIDTH;
    hist_nxt[DATA_WIDTH-1:0] = word_nxt;
    stuff_pos = (ones == OW'(MAX_ONES));
    word_done = (bcnt == CW'(DATA_WIDTH - 1));
  end

  // destuff, assemble and publish words; clear keeps rx_data
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      data_q  <= '0;
      hist    <= '0;
      bcnt    <= '0;
      ones    <= '0;
      valid_q <= 1'b0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      skip_q  <= 1'b0;
      if (rx.clear) begin
        sreg  <= '0;
        hist  <= '0;
        bcnt  <= '0;
        ones  <= '0;
        err_q <= 1'b0;
      end else if (rx.shift_enable) begin
        if (stuff_pos) begin
          ones <= '0;
          if (rx.d_in)
            err_q <= 1'b1;
          else
            skip_q <= 1'b1;
        end else begin
          sreg <= word_nxt;
          ones <= rx.d_in ? ones + OW'(1) : '0;
          if (word_done) begin
            bcnt    <= '0;
            data_q  <= word_nxt;
            hist    <= hist_nxt;
            valid_q <= 1'b1;
          end else begin
            bcnt <= bcnt + CW'(1);
          end
        end
      end
    end
  end

  assign rx.rx_data       = data_q;
  assign rx.rx_data_valid = valid_q;
  assign rx.rx_history    = hist;
  assign rx.stuff_skip    = skip_q;
  assign rx.stuff_error   = err_q;
  assign rx.bit_count     = bcnt;
endmodule
